// File: rtl/sirv_plic_target_core.sv
// sirv_plic_target_core
// PLIC-side endpoint for the level-gateway handshake. Each gateway presents
// io_gw_valid. The core latches it as pending, answers with io_gw_ready
// (low while pending), and later pulses io_gw_complete when the hart
// completes that source.
// Pending, enabled sources whose priority is above the threshold are
// arbitrated: the highest priority wins and ties go to the lowest ID. The
// winner is registered every cycle. That registered winner drives io_irq
// and io_claim_id.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   io_gw_valid         per-source interrupt request from the gateways
//   io_gw_ready         per-source ready back to the gateways (~pending)
//   io_gw_complete      registered one-cycle completion pulse per source
//   io_irq              registered interrupt request to the hart
//   io_claim_rd         claim strobe; io_claim_id is the claimed ID
//   io_claim_id         registered best ID, 0 when nothing is eligible
//   io_complete_valid   completion strobe
//   io_complete_id      ID being completed
//   io_cfg_we/addr/wdata  config write port:
//                         0 = threshold, 1..NUM_SRC = priority,
//                         NUM_SRC+1 = enable bitmap
//   io_cfg_rdata        combinational config read, zero-extended

module sirv_plic_target_core #(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = 4,
   parameter int PRIO_W  = 3,
   parameter int CFG_AW  = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_SRC-1:0] io_gw_valid,
   output logic [NUM_SRC-1:0] io_gw_ready,
   output logic [NUM_SRC-1:0] io_gw_complete,
   output logic              io_irq,
   input  logic              io_claim_rd,
   output logic [ID_W-1:0]   io_claim_id,
   input  logic              io_complete_valid,
   input  logic [ID_W-1:0]   io_complete_id,
   input  logic              io_cfg_we,
   input  logic [CFG_AW-1:0] io_cfg_addr,
   input  logic [31:0]       io_cfg_wdata,
   output logic [31:0]       io_cfg_rdata
);

   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] enable_q, enable_d;
   logic [PRIO_W-1:0]  prio_q [NUM_SRC];
   logic [PRIO_W-1:0]  prio_d [NUM_SRC];
   logic [PRIO_W-1:0]  threshold_q, threshold_d;
   logic [ID_W-1:0]    best_id_q, best_id_d;
   logic [PRIO_W-1:0]  best_prio_q, best_prio_d;
   logic               irq_q, irq_d;
   logic [NUM_SRC-1:0] gw_complete_q, gw_complete_d;

   logic               claim_fire;
   logic [NUM_SRC-1:0] claim_mask;
   logic [NUM_SRC-1:0] eligible;
   logic               win_found;

   // best_prio_q is kept for visibility of the arbitration result.
   // Only the low bits of the config write data are meaningful.
   logic unused_ok;
   assign unused_ok = ^{io_cfg_wdata, best_prio_q};

   assign io_gw_ready    = ~pending_q;
   assign io_gw_complete = gw_complete_q;
   assign io_irq         = irq_q;
   assign io_claim_id    = best_id_q;

   // Claim takes the registered winner. The claimed source is masked out of
   // this edge's arbitration, so the winner registered at the same edge can
   // never present the just-claimed ID a second time.
   always_comb begin
      claim_fire = io_claim_rd && (best_id_q != '0);
      claim_mask = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (claim_fire && (best_id_q == ID_W'(i + 1))) begin
            claim_mask[i] = 1'b1;
         end
      end
   end

   // Pending capture and clear. A handshake only completes while ready
   // (~pending) is high, so a source being claimed cannot be recaptured at
   // the same edge. The gateway re-presents it one cycle later.
   always_comb begin
      pending_d = (pending_q & ~claim_mask) | (io_gw_valid & ~pending_q);
   end

   // Arbitration over eligible sources. The strict '>' keeps the earliest
   // (lowest ID) source on a priority tie. Priority 0 can never exceed the
   // threshold, so a zero priority is never eligible.
   always_comb begin
      best_id_d   = '0;
      best_prio_d = '0;
      win_found   = 1'b0;
      eligible    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         eligible[i] = pending_q[i] && enable_q[i] && !claim_mask[i] &&
                       (prio_q[i] > threshold_q);
         if (eligible[i] && (!win_found || (prio_q[i] > best_prio_d))) begin
            win_found   = 1'b1;
            best_id_d   = ID_W'(i + 1);
            best_prio_d = prio_q[i];
         end
      end
      irq_d = win_found;
   end

   // Completion pulse decode. IDs outside 1..NUM_SRC match no bit and are
   // therefore ignored.
   always_comb begin
      gw_complete_d = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (io_complete_valid && (io_complete_id == ID_W'(i + 1))) begin
            gw_complete_d[i] = 1'b1;
         end
      end
   end

   // Config write decode. Values are truncated to the field widths, and
   // writes to unmapped addresses fall through with no effect.
   always_comb begin
      threshold_d = threshold_q;
      enable_d    = enable_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         prio_d[i] = prio_q[i];
      end
      if (io_cfg_we) begin
         if (io_cfg_addr == CFG_AW'(0)) begin
            threshold_d = io_cfg_wdata[PRIO_W-1:0];
         end
         if (io_cfg_addr == CFG_AW'(NUM_SRC + 1)) begin
            enable_d = io_cfg_wdata[NUM_SRC-1:0];
         end
         for (int i = 0; i < NUM_SRC; i++) begin
            if (io_cfg_addr == CFG_AW'(i + 1)) begin
               prio_d[i] = io_cfg_wdata[PRIO_W-1:0];
            end
         end
      end
   end

   // Config read mux. It is zero-extended, and unmapped addresses read 0.
   always_comb begin
      io_cfg_rdata = '0;
      if (io_cfg_addr == CFG_AW'(0)) begin
         io_cfg_rdata = 32'(threshold_q);
      end
      if (io_cfg_addr == CFG_AW'(NUM_SRC + 1)) begin
         io_cfg_rdata = 32'(enable_q);
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         if (io_cfg_addr == CFG_AW'(i + 1)) begin
            io_cfg_rdata = 32'(prio_q[i]);
         end
      end
   end

   // State registers. Reset clears everything on this side only. The
   // gateways hold their own in-flight state and need the same reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending_q     <= '0;
         enable_q      <= '0;
         threshold_q   <= '0;
         best_id_q     <= '0;
         best_prio_q   <= '0;
         irq_q         <= 1'b0;
         gw_complete_q <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            prio_q[i] <= '0;
         end
      end else begin
         pending_q     <= pending_d;
         enable_q      <= enable_d;
         threshold_q   <= threshold_d;
         best_id_q     <= best_id_d;
         best_prio_q   <= best_prio_d;
         irq_q         <= irq_d;
         gw_complete_q <= gw_complete_d;
         for (int i = 0; i < NUM_SRC; i++) begin
            prio_q[i] <= prio_d[i];
         end
      end
   end

endmodule

// File: tb/tb_sirv_plic_target_core.sv
// Directed testbench for sirv_plic_target_core (NUM_SRC=8).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.

module tb_sirv_plic_target_core;

   logic        clock;
   logic        reset;
   logic [7:0]  io_gw_valid;
   logic [7:0]  io_gw_ready;
   logic [7:0]  io_gw_complete;
   logic        io_irq;
   logic        io_claim_rd;
   logic [3:0]  io_claim_id;
   logic        io_complete_valid;
   logic [3:0]  io_complete_id;
   logic        io_cfg_we;
   logic [5:0]  io_cfg_addr;
   logic [31:0] io_cfg_wdata;
   logic [31:0] io_cfg_rdata;

   int checks = 0;
   int errors = 0;

   sirv_plic_target_core #(
      .NUM_SRC(8), .ID_W(4), .PRIO_W(3), .CFG_AW(6)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .io_gw_valid      (io_gw_valid),
      .io_gw_ready      (io_gw_ready),
      .io_gw_complete   (io_gw_complete),
      .io_irq           (io_irq),
      .io_claim_rd      (io_claim_rd),
      .io_claim_id      (io_claim_id),
      .io_complete_valid(io_complete_valid),
      .io_complete_id   (io_complete_id),
      .io_cfg_we        (io_cfg_we),
      .io_cfg_addr      (io_cfg_addr),
      .io_cfg_wdata     (io_cfg_wdata),
      .io_cfg_rdata     (io_cfg_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic cfg_write(input logic [5:0] addr, input logic [31:0] data);
      io_cfg_we    = 1'b1;
      io_cfg_addr  = addr;
      io_cfg_wdata = data;
      tick();
      io_cfg_we    = 1'b0;
      io_cfg_wdata = '0;
   endtask

   task automatic do_claim();
      io_claim_rd = 1'b1;
      tick();
      io_claim_rd = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if (io_irq !== 1'b0) begin
         errors++; $display("FAIL reset_irq: got %0b expected 0", io_irq);
      end
      checks++;
      if (io_claim_id !== 4'd0) begin
         errors++; $display("FAIL reset_claim_id: got %0d expected 0", io_claim_id);
      end
      checks++;
      if (io_gw_ready !== 8'hFF) begin
         errors++; $display("FAIL reset_gw_ready: got %h expected ff", io_gw_ready);
      end
      checks++;
      if (io_gw_complete !== 8'h00) begin
         errors++; $display("FAIL reset_gw_complete: got %h expected 00", io_gw_complete);
      end
      for (int a = 0; a < 10; a++) begin
         io_cfg_addr = 6'(a);
         #1;
         checks++;
         if (io_cfg_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_cfg_rdata[%0d]: got %h expected 0", a, io_cfg_rdata);
         end
      end
   endtask

   task automatic test_basic();
      cfg_write(6'd3, 32'd2);
      cfg_write(6'd9, 32'h04);
      cfg_write(6'd0, 32'd0);
      io_cfg_addr = 6'd3;
      #1;
      checks++;
      if (io_cfg_rdata !== 32'd2) begin
         errors++; $display("FAIL basic_prio3_read: got %h expected 2", io_cfg_rdata);
      end
      io_gw_valid = 8'h04;
      tick();
      io_gw_valid = 8'h00;
      checks++;
      if (io_gw_ready !== 8'hFB) begin
         errors++; $display("FAIL basic_gw_ready: got %h expected fb", io_gw_ready);
      end
      checks++;
      if (io_irq !== 1'b0) begin
         errors++; $display("FAIL basic_irq_edge1: got %0b expected 0", io_irq);
      end
      tick();
      checks++;
      if (io_irq !== 1'b1) begin
         errors++; $display("FAIL basic_irq_edge2: got %0b expected 1", io_irq);
      end
      checks++;
      if (io_claim_id !== 4'd3) begin
         errors++; $display("FAIL basic_claim_id: got %0d expected 3", io_claim_id);
      end
      do_claim();
      checks++;
      if (io_claim_id !== 4'd0 || io_irq !== 1'b0 || io_gw_ready !== 8'hFF) begin
         errors++;
         $display("FAIL basic_after_claim: got id=%0d irq=%0b ready=%h expected id=0 irq=0 ready=ff",
                  io_claim_id, io_irq, io_gw_ready);
      end
   endtask

   task automatic test_tie();
      cfg_write(6'd2, 32'd4);
      cfg_write(6'd5, 32'd4);
      cfg_write(6'd9, 32'h12);
      io_gw_valid = 8'h12;
      tick();
      io_gw_valid = 8'h00;
      tick();
      checks++;
      if (io_claim_id !== 4'd2 || io_irq !== 1'b1) begin
         errors++; $display("FAIL tie_lowest_id: got id=%0d irq=%0b expected id=2 irq=1", io_claim_id, io_irq);
      end
      do_claim();
      checks++;
      if (io_claim_id !== 4'd5) begin
         errors++; $display("FAIL tie_second_claim_id: got %0d expected 5", io_claim_id);
      end
      checks++;
      if (io_gw_ready !== 8'hEF) begin
         errors++; $display("FAIL tie_pending_cleared: got %h expected ef", io_gw_ready);
      end
      do_claim();
      checks++;
      if (io_claim_id !== 4'd0 || io_irq !== 1'b0) begin
         errors++; $display("FAIL tie_drained: got id=%0d irq=%0b expected id=0 irq=0", io_claim_id, io_irq);
      end
   endtask

   task automatic test_priority();
      // Source 3 priority 2, source 5 priority 4: the higher ID wins on priority.
      cfg_write(6'd9, 32'h14);
      io_gw_valid = 8'h14;
      tick();
      io_gw_valid = 8'h00;
      tick();
      checks++;
      if (io_claim_id !== 4'd5) begin
         errors++; $display("FAIL prio_high_wins: got %0d expected 5", io_claim_id);
      end
      do_claim();
      checks++;
      if (io_claim_id !== 4'd3 || io_irq !== 1'b1) begin
         errors++; $display("FAIL prio_next: got id=%0d irq=%0b expected id=3 irq=1", io_claim_id, io_irq);
      end
      do_claim();
      checks++;
      if (io_claim_id !== 4'd0) begin
         errors++; $display("FAIL prio_drained: got %0d expected 0", io_claim_id);
      end
      // A claim with nothing to claim changes nothing.
      do_claim();
      checks++;
      if (io_claim_id !== 4'd0 || io_gw_ready !== 8'hFF) begin
         errors++; $display("FAIL prio_empty_claim: got id=%0d ready=%h expected id=0 ready=ff", io_claim_id, io_gw_ready);
      end
   endtask

   task automatic test_threshold();
      cfg_write(6'd1, 32'd1);
      cfg_write(6'd9, 32'h01);
      cfg_write(6'd0, 32'd1);
      io_gw_valid = 8'h01;
      tick();
      io_gw_valid = 8'h00;
      tick();
      tick();
      checks++;
      if (io_irq !== 1'b0 || io_claim_id !== 4'd0) begin
         errors++; $display("FAIL thr_blocked: got irq=%0b id=%0d expected irq=0 id=0", io_irq, io_claim_id);
      end
      checks++;
      if (io_gw_ready !== 8'hFE) begin
         errors++; $display("FAIL thr_pending_held: got %h expected fe", io_gw_ready);
      end
      io_cfg_addr = 6'd0;
      #1;
      checks++;
      if (io_cfg_rdata !== 32'd1) begin
         errors++; $display("FAIL thr_read: got %h expected 1", io_cfg_rdata);
      end
      cfg_write(6'd0, 32'd0);
      checks++;
      if (io_irq !== 1'b0) begin
         errors++; $display("FAIL thr_irq_edge1: got %0b expected 0", io_irq);
      end
      tick();
      checks++;
      if (io_irq !== 1'b1 || io_claim_id !== 4'd1) begin
         errors++; $display("FAIL thr_irq_edge2: got irq=%0b id=%0d expected irq=1 id=1", io_irq, io_claim_id);
      end
      do_claim();
      checks++;
      if (io_claim_id !== 4'd0) begin
         errors++; $display("FAIL thr_cleared: got %0d expected 0", io_claim_id);
      end
   endtask

   task automatic test_config();
      cfg_write(6'd7, 32'hFF);
      io_cfg_addr = 6'd7;
      #1;
      checks++;
      if (io_cfg_rdata !== 32'd7) begin
         errors++; $display("FAIL cfg_prio_trunc: got %h expected 7", io_cfg_rdata);
      end
      cfg_write(6'd9, 32'h1FF);
      io_cfg_addr = 6'd9;
      #1;
      checks++;
      if (io_cfg_rdata !== 32'hFF) begin
         errors++; $display("FAIL cfg_enable_trunc: got %h expected ff", io_cfg_rdata);
      end
      cfg_write(6'd10, 32'h5);
      io_cfg_addr = 6'd10;
      #1;
      checks++;
      if (io_cfg_rdata !== 32'd0) begin
         errors++; $display("FAIL cfg_unmapped: got %h expected 0", io_cfg_rdata);
      end
      cfg_write(6'd7, 32'd0);
   endtask

   task automatic test_complete();
      io_complete_valid = 1'b1;
      io_complete_id    = 4'd4;
      tick();
      io_complete_valid = 1'b0;
      checks++;
      if (io_gw_complete !== 8'h08) begin
         errors++; $display("FAIL cpl_id4: got %h expected 08", io_gw_complete);
      end
      tick();
      checks++;
      if (io_gw_complete !== 8'h00) begin
         errors++; $display("FAIL cpl_one_cycle: got %h expected 00", io_gw_complete);
      end
      io_complete_valid = 1'b1;
      io_complete_id    = 4'd0;
      tick();
      checks++;
      if (io_gw_complete !== 8'h00) begin
         errors++; $display("FAIL cpl_id0: got %h expected 00", io_gw_complete);
      end
      io_complete_id = 4'd9;
      tick();
      checks++;
      if (io_gw_complete !== 8'h00) begin
         errors++; $display("FAIL cpl_id9: got %h expected 00", io_gw_complete);
      end
      io_complete_id = 4'd8;
      tick();
      io_complete_valid = 1'b0;
      checks++;
      if (io_gw_complete !== 8'h80) begin
         errors++; $display("FAIL cpl_id8: got %h expected 80", io_gw_complete);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      // Claim of source 6 while its gateway keeps valid high. A completion
      // for source 6 lands on the same edge as the claim.
      cfg_write(6'd6, 32'd3);
      cfg_write(6'd9, 32'h20);
      io_gw_valid = 8'h20;
      tick();
      checks++;
      if (io_gw_ready !== 8'hDF) begin
         errors++; $display("FAIL b2b_captured: got %h expected df", io_gw_ready);
      end
      tick();
      checks++;
      if (io_irq !== 1'b1 || io_claim_id !== 4'd6) begin
         errors++; $display("FAIL b2b_irq: got irq=%0b id=%0d expected irq=1 id=6", io_irq, io_claim_id);
      end
      io_complete_valid = 1'b1;
      io_complete_id    = 4'd6;
      do_claim();
      io_complete_valid = 1'b0;
      checks++;
      if (io_gw_ready !== 8'hFF || io_irq !== 1'b0 || io_claim_id !== 4'd0) begin
         errors++;
         $display("FAIL b2b_claimed: got ready=%h irq=%0b id=%0d expected ready=ff irq=0 id=0",
                  io_gw_ready, io_irq, io_claim_id);
      end
      checks++;
      if (io_gw_complete !== 8'h20) begin
         errors++; $display("FAIL b2b_complete: got %h expected 20", io_gw_complete);
      end
      tick();
      checks++;
      if (io_gw_ready !== 8'hDF || io_irq !== 1'b0) begin
         errors++; $display("FAIL b2b_recapture: got ready=%h irq=%0b expected ready=df irq=0", io_gw_ready, io_irq);
      end
      tick();
      checks++;
      if (io_irq !== 1'b1 || io_claim_id !== 4'd6) begin
         errors++; $display("FAIL b2b_reassert: got irq=%0b id=%0d expected irq=1 id=6", io_irq, io_claim_id);
      end
      io_gw_valid = 8'h00;
      do_claim();
   endtask

   task automatic test_reset_mid();
      // Priorities: source 2 = 4 (set earlier), source 3 = 2 (set earlier), source 4 = 1.
      cfg_write(6'd4, 32'd1);
      cfg_write(6'd9, 32'h0E);
      io_gw_valid = 8'h0E;
      tick();
      io_gw_valid = 8'h00;
      io_complete_valid = 1'b1;
      io_complete_id    = 4'd1;
      tick();
      io_complete_valid = 1'b0;
      checks++;
      if (io_irq !== 1'b1 || io_claim_id !== 4'd2 || io_gw_complete !== 8'h01) begin
         errors++;
         $display("FAIL rst_mid_pre: got irq=%0b id=%0d cpl=%h expected irq=1 id=2 cpl=01",
                  io_irq, io_claim_id, io_gw_complete);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (io_irq !== 1'b0 || io_claim_id !== 4'd0 || io_gw_complete !== 8'h00 || io_gw_ready !== 8'hFF) begin
         errors++;
         $display("FAIL rst_mid_outputs: got irq=%0b id=%0d cpl=%h ready=%h expected 0 0 00 ff",
                  io_irq, io_claim_id, io_gw_complete, io_gw_ready);
      end
      for (int a = 0; a < 10; a++) begin
         io_cfg_addr = 6'(a);
         #1;
         checks++;
         if (io_cfg_rdata !== 32'd0) begin
            errors++; $display("FAIL rst_mid_cfg[%0d]: got %h expected 0", a, io_cfg_rdata);
         end
      end
      reset = 1'b0;
      tick();
   endtask

   initial begin
      reset             = 1'b1;
      io_gw_valid       = '0;
      io_claim_rd       = 1'b0;
      io_complete_valid = 1'b0;
      io_complete_id    = '0;
      io_cfg_we         = 1'b0;
      io_cfg_addr       = '0;
      io_cfg_wdata      = '0;
      test_reset();
      test_basic();
      test_tie();
      test_priority();
      test_threshold();
      test_config();
      test_complete();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sirv_plic_target_core.md
Name: sirv_plic_target_core

Overview:
PLIC-side endpoint for the gateway handshake: consumes per-source valid lines from level gateways, latches them as pending, and returns ready and complete to each gateway. It arbitrates pending, enabled sources by priority against a threshold and drives a registered interrupt line to one hart. The hart-side claim/complete port clears pending on claim and pulses the matching gateway complete. A small config write/read port holds priorities, enables and threshold.

Parameters:
NUM_SRC, 8, number of interrupt sources; IDs 1..NUM_SRC; ID 0 = none
ID_W, 4, width of source IDs; NUM_SRC < 2^ID_W required
PRIO_W, 3, priority/threshold width
CFG_AW, 6, config address width; NUM_SRC+1 < 2^CFG_AW required

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high reset
io_gw_valid  in  NUM_SRC  bit i = gateway for source i+1 presents interrupt
io_gw_ready  out  NUM_SRC  bit i = ~pending[i] (combinational)
io_gw_complete  out  NUM_SRC  registered one-cycle complete pulse per source
io_irq  out  1  registered: eligible source exists
io_claim_rd  in  1  claim strobe, one cycle
io_claim_id  out  ID_W  best_id_q (registered arbitration result), 0 if none
io_complete_valid  in  1  completion strobe
io_complete_id  in  ID_W  ID being completed
io_cfg_we  in  1  config write enable
io_cfg_addr  in  CFG_AW  0 = threshold; 1..NUM_SRC = priority[id]; NUM_SRC+1 = enable bitmap
io_cfg_wdata  in  32  write data, low bits used
io_cfg_rdata  out  32  combinational read of io_cfg_addr, zero-extended; unmapped reads 0

Behaviour:
- Reset: pending, enable, priorities, threshold, best_id_q, best_prio_q, io_irq, io_gw_complete all 0.
- Gateway handshake: set pending[i] at edge when io_gw_valid[i] & io_gw_ready[i]. Pending is cleared only by claim. Enable does not gate pending capture.
- Eligible[i] = pending[i] & enable[i] & (priority[i] > threshold). Priority 0 never eligible.
- Arbitration: combinational winner over eligible & ~claim_mask. Highest priority wins. Ties go to the lowest ID. Winner registered into best_id_q/best_prio_q every cycle. io_irq <= (winner exists). Latency from gateway valid to io_irq: 2 edges (pending set, then arbitration reg).
- Claim: io_claim_rd samples io_claim_id = best_id_q in the same cycle. If best_id_q != 0, clear pending[best_id_q] at that edge. claim_mask excludes the same ID from that edge's arbitration, so the claimed ID is never presented twice. A claim with best_id_q = 0 changes nothing.
- Same-edge claim and gateway valid on the same source: no conflict; ready is 0 while pending.
- Complete: io_complete_valid with io_complete_id in 1..NUM_SRC -> io_gw_complete[id-1] = 1 for exactly the next cycle. ID 0 or out-of-range: ignored. Completion does not depend on enable or pending. Completing an unclaimed ID still pulses; gateway semantics apply.
- Simultaneous claim and complete: both take effect independently.
- Config writes take effect at the edge and affect arbitration from that edge onward (io_irq one cycle later). Writes to unmapped addresses are ignored. Priority and threshold are truncated to PRIO_W; enable is truncated to NUM_SRC.
- Reset asserted mid-operation clears all state at the next edge. The gateway-side in-flight state is not touched, so the system reset must cover both.

Test Plan:
- Reset, then prio[3]=2, enable=0x04, threshold=0; pulse gw_valid[2] -> gw_ready[2]=0 next cycle, io_irq=1 two edges after valid, io_claim_id=3.
- Sources 2 and 5 pending, prio 4 and 4, both enabled -> claim_id=2. Claim -> next cycle claim_id=5 and pending[1]=0. Claim again -> claim_id=0, io_irq=0.
- prio[1]=1, threshold=1, source 1 pending and enabled -> io_irq=0 and claim_id=0. Write threshold=0 -> io_irq=1 after 2 edges.
- complete_valid with id=4 -> io_gw_complete=0x08 for exactly one cycle. id=0 or id=9 -> no pulse.
- Claim source 6 while gw_valid[5] is held high -> pending cleared, gw_ready[5]=1 next cycle, re-captured at the following edge, io_irq reasserts.
- Assert reset with 3 sources pending and io_irq=1 -> all outputs 0 after one edge, cfg_rdata of every address = 0.
